// File: rtl/div_wait_unit_pkg.sv
// Shared types and constants for the multi-cycle divide unit.
// Holds the FSM state encoding, datapath width and iteration count.
package div_wait_unit_pkg;

   localparam int DIV_W     = 32;
   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Two's-complement magnitude when neg is set; raw value otherwise.
   function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v,
                                                  input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/div_wait_unit_if.sv
// Request/result bundle between a pipeline wait stage and the divide unit.
// master = requester side, slave = divide unit side.
interface div_wait_unit_if;
   import div_wait_unit_pkg::*;

   logic             start;
   logic             is_signed;
   logic [DIV_W-1:0] dividend;
   logic [DIV_W-1:0] divisor;
   logic             flush;
   logic             busy;
   logic             done;
   logic [DIV_W-1:0] quotient;
   logic [DIV_W-1:0] remainder;
   logic             pipe_en;

   modport master (
      output start, is_signed, dividend, divisor, flush,
      input  busy, done, quotient, remainder, pipe_en
   );

   modport slave (
      input  start, is_signed, dividend, divisor, flush,
      output busy, done, quotient, remainder, pipe_en
   );

endinterface

// File: rtl/div_wait_unit_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
   import div_wait_unit_pkg::*;
(
   input  logic [DIV_W:0]   rem_in,
   input  logic [DIV_W-1:0] quo_in,
   input  logic [DIV_W-1:0] dvsr,
   output logic [DIV_W:0]   rem_out,
   output logic [DIV_W-1:0] quo_out
);

   logic [DIV_W+1:0] diff;
   logic             fits;

   // rem_in stays below the divisor, so the extra top bit acts as the borrow.
   always_comb begin
      diff    = {rem_in, quo_in[DIV_W-1]} - {2'b00, dvsr};
      fits    = ~diff[DIV_W+1];
      rem_out = fits ? diff[DIV_W:0] : {rem_in[DIV_W-1:0], quo_in[DIV_W-1]};
      quo_out = {quo_in[DIV_W-2:0], fits};
   end

endmodule

// File: rtl/div_wait_unit.sv
// Multi-cycle DIV/DIVU unit with IDLE/BUSY/DONE control, sign fix-up and a
// hold enable for the downstream wait-stage register bank.
module div_wait_unit
   import div_wait_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   div_wait_unit_if.slave bus
);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             iter_last;
   logic [5:0]       cnt;
   logic [DIV_W:0]   rem_q;
   logic [DIV_W:0]   rem_nxt;
   logic [DIV_W-1:0] quo_q;
   logic [DIV_W-1:0] quo_nxt;
   logic [DIV_W-1:0] dvsr_q;
   logic             qsign_q;
   logic             rsign_q;
   logic [DIV_W-1:0] quotient_q;
   logic [DIV_W-1:0] remainder_q;
   logic             sign_a;
   logic             sign_b;

   function automatic logic [DIV_W-1:0] sign_fix(input logic [DIV_W-1:0] mag,
                                                 input logic neg);
      return neg ? -mag : mag;
   endfunction

   assign sign_a    = bus.is_signed & bus.dividend[DIV_W-1];
   assign sign_b    = bus.is_signed & bus.divisor[DIV_W-1];
   assign accept    = bus.start & ~bus.flush & (state != ST_BUSY);
   assign iter_last = (cnt == 6'(DIV_ITERS));

   div_step u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .dvsr    (dvsr_q),
      .rem_out (rem_nxt),
      .quo_out (quo_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: state_nxt = accept ? ST_BUSY : ST_IDLE;
            ST_BUSY:          if (iter_last) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
         endcase
      end
   end

   // The wait stage holds while dividing and in the accept cycle itself.
   always_comb begin
      bus.busy    = (state == ST_BUSY);
      bus.done    = (state == ST_DONE);
      bus.pipe_en = rst | ((state != ST_BUSY) & ~accept);
   end

   // Counter runs 0..DIV_ITERS; the extra cycle at DIV_ITERS does the sign fix.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         qsign_q     <= 1'b0;
         rsign_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else if (accept) begin
         cnt     <= '0;
         rem_q   <= '0;
         quo_q   <= magnitude(bus.dividend, sign_a);
         dvsr_q  <= magnitude(bus.divisor, sign_b);
         qsign_q <= sign_a ^ sign_b;
         rsign_q <= sign_a;
      end else if ((state == ST_BUSY) && !bus.flush) begin
         if (!iter_last) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + 6'd1;
         end else begin
            // Divide by zero reports all-ones regardless of operand signs.
            quotient_q  <= (dvsr_q == '0) ? '1 : sign_fix(quo_q, qsign_q);
            remainder_q <= sign_fix(rem_q[DIV_W-1:0], rsign_q);
         end
      end
   end

   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_div_wait_unit.sv
// Randomized and directed bench for div_wait_unit against a behavioural
// model built from integer division and an edge-count latency rule.
module tb_div_wait_unit;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   bit   chk_en;

   div_wait_unit_if bus ();

   div_wait_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   input bit s, output logic [31:0] q,
                                   output logic [31:0] r);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   // Behavioural model: a request is taken when idle/done and not flushed;
   // its result shows up 33 edges later unless flushed or reset first.
   bit          m_active;
   bit          m_done;
   int          m_k;
   logic [31:0] m_q;
   logic [31:0] m_r;
   logic [31:0] p_q;
   logic [31:0] p_r;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_k      = 0;
         m_q      = 32'd0;
         m_r      = 32'd0;
      end else if (bus.flush) begin
         m_active = 1'b0;
         m_done   = 1'b0;
      end else if (bus.start && !m_active) begin
         ref_div(bus.dividend, bus.divisor, bus.is_signed, p_q, p_r);
         m_active = 1'b1;
         m_done   = 1'b0;
         m_k      = 0;
      end else if (m_active) begin
         m_k++;
         if (m_k == 33) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_q      = p_q;
            m_r      = p_r;
         end
      end else begin
         m_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(bus.busy), 32'(m_active));
         check("done", 32'(bus.done), 32'(m_done));
         check("pipe_en", 32'(bus.pipe_en),
               32'(rst || (!m_active && !(bus.start && !bus.flush))));
         check("quotient", bus.quotient, m_q);
         check("remainder", bus.remainder, m_r);
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s);
      bus.dividend  = a;
      bus.divisor   = b;
      bus.is_signed = s;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) return;
      end
      n = -1;
   endtask

   task automatic expect_op(input string nm, input logic [31:0] eq, input logic [31:0] er);
      int n;
      wait_done(n);
      check({nm, "_latency"}, 32'(n), 32'd33);
      check({nm, "_q"}, bus.quotient, eq);
      check({nm, "_r"}, bus.remainder, er);
   endtask

   task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input bit s, input logic [31:0] eq, input logic [31:0] er);
      logic [31:0] q;
      logic [31:0] r;
      ref_div(a, b, s, q, r);
      check({nm, "_model_q"}, q, eq);
      check({nm, "_model_r"}, r, er);
      issue(a, b, s);
      expect_op(nm, eq, er);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int n;
      int dones;
      errors        = 0;
      checks        = 0;
      chk_en        = 1'b0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.flush     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'd0;
      bus.divisor   = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_pipe_en", 32'(bus.pipe_en), 32'd1);
      check("reset_q", bus.quotient, 32'd0);
      check("reset_r", bus.remainder, 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;
      @(posedge clk);
      #1;

      directed("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
      directed("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      directed("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
      directed("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
      directed("u_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
      directed("div0_u", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234);
      directed("div0_s", 32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);

      // Flush during the 10th busy cycle, with a start that must be ignored.
      issue(32'd1000, 32'd3, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      check("flush_busy", 32'(bus.busy), 32'd0);
      check("flush_done", 32'(bus.done), 32'd0);
      check("flush_pipe_en", 32'(bus.pipe_en), 32'd1);
      check("flush_q_held", bus.quotient, 32'hFFFF_FFFF);
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check("flush_no_done", 32'(dones), 32'd0);
      directed("after_flush", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);

      // Reset in the middle of a divide.
      issue(32'd5000, 32'd9, 1'b0);
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_q", bus.quotient, 32'd0);
      check("midrst_r", bus.remainder, 32'd0);
      check("midrst_pipe_en", 32'(bus.pipe_en), 32'd1);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check("midrst_no_done", 32'(dones), 32'd0);

      // Back-to-back: second start issued in the done cycle of the first.
      issue(32'd77, 32'd10, 1'b0);
      expect_op("b2b_first", 32'd7, 32'd7);
      issue(32'hFFFF_FFF9, 32'd3, 1'b1);
      expect_op("b2b_second", 32'hFFFF_FFFE, 32'hFFFF_FFFF);

      // Random traffic including starts while busy and stray flushes.
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         bus.start     = ($urandom_range(0, 7) == 0);
         bus.flush     = ($urandom_range(0, 63) == 0);
         bus.is_signed = 1'($urandom_range(0, 1));
         bus.dividend  = pick();
         bus.divisor   = pick();
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
      repeat (40) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
